// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: state encoding, digit limits
// and the prescaler width helper used by the top level.
package bcd_stopwatch_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         DIGITS_DEFAULT = 4;

  // Prescaler needs clog2(div) bits, but never fewer than one so the
  // register still exists when every tick increments.
  function automatic int presc_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control and display bus between the stopwatch and its surroundings:
// tick/button pulses in, packed BCD count and status flags out.
interface bcd_stopwatch_if;
  import bcd_stopwatch_pkg::*;

  logic                          tick;
  logic                          start_stop;
  logic                          clear;
  logic [4*DIGITS_DEFAULT-1:0]   data;
  logic                          running;
  logic                          wrap;

  // Driver side: the clock divider, debounced buttons and the display
  modport master (
    output tick,
    output start_stop,
    output clear,
    input  data,
    input  running,
    input  wrap
  );

  // Stopwatch side
  modport slave (
    input  tick,
    input  start_stop,
    input  clear,
    output data,
    output running,
    output wrap
  );

endinterface

// File: rtl/bcd_stopwatch_digit.sv
// One decade cell of the BCD counter. Rolls 9 -> 0 and raises a
// combinational carry in the same cycle so a chain of cells ripples
// the whole increment within one clock.
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic at_max;

  assign at_max = (digit == BCD_MAX);
  assign carry  = inc & at_max;

  // Digit register: reset/clear to zero, otherwise step on inc with decade wrap
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        digit <= 4'd0;
      end else begin
        digit <= digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Stopwatch producing a packed-BCD count for the seven-segment display.
// Qualified ticks are divided by TICK_DIV and then ripple through a
// chain of decade cells. CLEAR beats START_STOP, which beats counting;
// a tick is judged against the state held before the edge.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int DIGITS   = DIGITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_stopwatch_if.slave       bus
);

  localparam int             PW         = presc_width(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_t            state_q;
  state_t            state_d;
  logic [PW-1:0]     presc_q;
  logic              count_en;
  logic              inc_pulse;
  logic              wrap_q;
  logic [DIGITS:0]   carry_chain;
  logic [3:0]        digits [DIGITS];

  // A tick only counts while running and when no clear is pending this cycle
  assign count_en  = (state_q == ST_RUNNING) && bus.tick && !bus.clear;
  assign inc_pulse = count_en && (presc_q == PRESC_LAST);

  // Run/stop state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear forces stopped, otherwise start_stop toggles
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_STOPPED;
    end else if (bus.start_stop) begin
      state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  // Prescaler keeps its value across a pause so a resumed run finishes the partial interval
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      presc_q <= '0;
    end else if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign carry_chain[0] = inc_pulse;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear),
      .inc   (carry_chain[i]),
      .digit (digits[i]),
      .carry (carry_chain[i+1])
    );
    assign bus.data[4*i +: 4] = digits[i];
  end

  // Wrap flag is the carry out of the top digit, registered so it lines up with the 0000 display
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= carry_chain[DIGITS];
    end
  end

  assign bus.wrap    = wrap_q;
  assign bus.running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: three instances (TICK_DIV 10, 4, 1) share
// one stimulus stream and are checked every cycle against an integer
// reference model, plus directed checks at the scenario milestones.
module tb_bcd_stopwatch;
  import bcd_stopwatch_pkg::*;

  logic clk;
  logic rst;

  bcd_stopwatch_if bus10 ();
  bcd_stopwatch_if bus4 ();
  bcd_stopwatch_if bus1 ();

  bcd_stopwatch #(.TICK_DIV(10), .DIGITS(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  bcd_stopwatch #(.TICK_DIV(4),  .DIGITS(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
  bcd_stopwatch #(.TICK_DIV(1),  .DIGITS(4)) dut1  (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  int divs    [3] = '{10, 4, 1};
  int m_count [3];
  int m_presc [3];
  bit m_run   [3];
  bit m_wrap  [3];

  logic [15:0] obs_data [3];
  logic        obs_run  [3];
  logic        obs_wrap [3];

  assign obs_data[0] = bus10.data;
  assign obs_data[1] = bus4.data;
  assign obs_data[2] = bus1.data;
  assign obs_run[0]  = bus10.running;
  assign obs_run[1]  = bus4.running;
  assign obs_run[2]  = bus1.running;
  assign obs_wrap[0] = bus10.wrap;
  assign obs_wrap[1] = bus4.wrap;
  assign obs_wrap[2] = bus1.wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation and tally the outcome
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] toBcd(input int c);
    logic [15:0] v;
    v[15:12] = 4'((c / 1000) % 10);
    v[11:8]  = 4'((c / 100) % 10);
    v[7:4]   = 4'((c / 10) % 10);
    v[3:0]   = 4'(c % 10);
    return v;
  endfunction

  function automatic bit nibblesOk(input logic [15:0] d);
    bit ok;
    ok = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (((d >> (4 * n)) & 16'hF) > 16'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Behavioural step: counts as a plain integer, BCD only at comparison time
  task automatic modelStep(input bit r, input bit clr, input bit ss, input bit tk);
    for (int i = 0; i < 3; i++) begin
      if (r || clr) begin
        m_count[i] = 0;
        m_presc[i] = 0;
        m_run[i]   = 1'b0;
        m_wrap[i]  = 1'b0;
      end else begin
        m_wrap[i] = 1'b0;
        if (m_run[i] && tk) begin
          m_presc[i]++;
          if (m_presc[i] == divs[i]) begin
            m_presc[i] = 0;
            m_count[i]++;
            if (m_count[i] == 10000) begin
              m_count[i] = 0;
              m_wrap[i]  = 1'b1;
            end
          end
        end
        if (ss) m_run[i] = !m_run[i];
      end
    end
  endtask

  // Drive one cycle of inputs to every instance, advance the model, check all outputs
  task automatic applyStimulus(input bit r, input bit clr, input bit ss, input bit tk);
    rst = r;
    bus10.clear = clr; bus10.start_stop = ss; bus10.tick = tk;
    bus4.clear  = clr; bus4.start_stop  = ss; bus4.tick  = tk;
    bus1.clear  = clr; bus1.start_stop  = ss; bus1.tick  = tk;
    @(posedge clk);
    modelStep(r, clr, ss, tk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("data[%0d]", i), 32'(obs_data[i]), 32'(toBcd(m_count[i])));
      checkOutput($sformatf("running[%0d]", i), 32'(obs_run[i]), 32'(m_run[i]));
      checkOutput($sformatf("wrap[%0d]", i), 32'(obs_wrap[i]), 32'(m_wrap[i]));
      checkOutput($sformatf("nibble_ok[%0d]", i), 32'(nibblesOk(obs_data[i])), 32'd1);
    end
  endtask

  task automatic ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic restart();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus10.clear = 1'b0; bus10.start_stop = 1'b0; bus10.tick = 1'b0;
    bus4.clear  = 1'b0; bus4.start_stop  = 1'b0; bus4.tick  = 1'b0;
    bus1.clear  = 1'b0; bus1.start_stop  = 1'b0; bus1.tick  = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_data", 32'(bus1.data), 32'h0);
    checkOutput("reset_running", 32'(bus1.running), 32'h0);

    // Reset while running at 0042, with other inputs active
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(42, 0);
    checkOutput("pre_reset_0042", 32'(bus1.data), 32'h0042);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_data", 32'(bus1.data), 32'h0000);
    checkOutput("rst_running", 32'(bus1.running), 32'h0);
    checkOutput("rst_wrap", 32'(bus1.wrap), 32'h0);

    // TICK_DIV=10: 25 spaced ticks -> 2, five more -> 3
    restart();
    ticks(25, 2);
    checkOutput("div10_25", 32'(bus10.data), 32'h0002);
    ticks(5, 2);
    checkOutput("div10_30", 32'(bus10.data), 32'h0003);

    // TICK_DIV=4: pause keeps the partial interval
    restart();
    ticks(6, 0);
    checkOutput("div4_run6", 32'(bus4.data), 32'h0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(10, 0);
    checkOutput("div4_paused", 32'(bus4.data), 32'h0001);
    checkOutput("div4_paused_run", 32'(bus4.running), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2, 0);
    checkOutput("div4_resume", 32'(bus4.data), 32'h0002);

    // Simultaneous events
    restart();
    ticks(123, 0);
    checkOutput("sim_0123", 32'(bus1.data), 32'h0123);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("sim_clr_data", 32'(bus1.data), 32'h0000);
    checkOutput("sim_clr_running", 32'(bus1.running), 32'h0);
    checkOutput("sim_clr_wrap", 32'(bus1.wrap), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ss_tick_running", 32'(bus1.running), 32'h1);
    checkOutput("ss_tick_data", 32'(bus1.data), 32'h0000);

    // Carry chain
    restart();
    ticks(99, 0);
    checkOutput("carry_0099", 32'(bus1.data), 32'h0099);
    ticks(1, 0);
    checkOutput("carry_0100", 32'(bus1.data), 32'h0100);
    ticks(899, 0);
    checkOutput("carry_0999", 32'(bus1.data), 32'h0999);
    ticks(1, 0);
    checkOutput("carry_1000", 32'(bus1.data), 32'h1000);

    // Wrap
    restart();
    ticks(9999, 0);
    checkOutput("wrap_9999", 32'(bus1.data), 32'h9999);
    checkOutput("wrap_before", 32'(bus1.wrap), 32'h0);
    ticks(1, 0);
    checkOutput("wrap_data", 32'(bus1.data), 32'h0000);
    checkOutput("wrap_pulse", 32'(bus1.wrap), 32'h1);
    checkOutput("wrap_running", 32'(bus1.running), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_one_cycle", 32'(bus1.wrap), 32'h0);
    ticks(3, 0);
    checkOutput("wrap_continues", 32'(bus1.data), 32'h0003);

    // Randomized mix of all controls
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 79) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
